// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_pkg
//  Brief    : Shared types and defaults for the instruction prefetch unit.
//  Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    // Fetch sequencer states: idle/issuing, waiting on a live response,
    // waiting on a response that a redirect has made stale.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RSP = 2'd1,
        ST_DROP     = 2'd2
    } fetch_state_t;

    localparam int          DEPTH_DEFAULT    = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : ifetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Brief    : Small synchronous FIFO with flush; head entry shown
//             combinationally. Flush beats push/pop in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_head_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push      = i_push && (r_count != c_FULL);
    assign w_pop       = i_pop  && (r_count != '0);
    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

    // Storage array: written at the tail, no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (reset && !i_flush && w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk) begin
        if (!reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/ifetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_prefetch_unit
//  Brief    : Instruction prefetcher - one outstanding word read at a time,
//             responses queued in a FIFO for the core, redirect flushes.
//             Optional macro IFETCH_PERF_EN adds fetch/flush counters.
//  Revision : 1.0 - initial release
// ============================================================================
module ifetch_prefetch_unit
    import ifetch_pkg::*;
#(
    parameter int          DEPTH    = DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic               r_en;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_pending_pc;
    logic [63:0]        r_last;
    logic [63:0]        w_head;
    logic [c_CNT_W-1:0] w_count;
    logic               w_grant;
    logic               w_push;
    logic               w_pop;
    logic               w_unused;

    // Low address bits of a redirect target are meaningless for word fetch.
    assign w_unused = &{1'b0, redirect_pc[1:0]};

    assign inst_valid = (w_count != '0);
    assign w_pop      = inst_valid && inst_ready && !redirect_valid;
    assign mem_addr   = r_fetch_pc;
    assign inst_data  = inst_valid ? w_head[63:32] : r_last[63:32];
    assign inst_pc    = inst_valid ? w_head[31:0]  : r_last[31:0];

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data ({mem_rdata, r_pending_pc}),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head_data (w_head),
        .o_count     (w_count)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, request decode (registers only) and buffer write strobe.
    always_comb begin
        w_state_nxt = r_state;
        mem_req     = r_en && (r_state == ST_IDLE) && (w_count < c_DEPTH);
        w_grant     = mem_req && mem_gnt;
        w_push      = (r_state == ST_WAIT_RSP) && mem_rvalid && !redirect_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = redirect_valid ? ST_DROP : ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end else if (redirect_valid) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Fetch address, in-flight address and held output for an empty buffer.
    // r_en keeps mem_req low during the reset cycle itself.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_en         <= 1'b0;
            r_fetch_pc   <= RESET_PC;
            r_pending_pc <= RESET_PC;
            r_last       <= '0;
        end else begin
            r_en <= 1'b1;
            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_grant) begin
                r_pending_pc <= r_fetch_pc;
            end
            if (inst_valid) begin
                r_last <= w_head;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    // Performance counters: buffer pushes and redirect cycles, free-running.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (w_push) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule : ifetch_prefetch_unit
`default_nettype wire

// File: doc/ifetch_prefetch_unit.md
IFETCH_PREFETCH_UNIT -- requirements
Module: ifetch_prefetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set instruction buffer entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous, active-low; low at a rising clk edge resets the block.
REQ-005 redirect_valid  input  1  SHALL flush the buffer and restart fetch (taken branch/jump from core).
REQ-006 redirect_pc  input  32  SHALL give the restart address; bits [1:0] ignored (treated as 0).
REQ-007 mem_req  output  1  SHALL request one instruction-word read from memory.
REQ-008 mem_addr  output  32  SHALL give the word-aligned read address.
REQ-009 mem_gnt  input  1  SHALL accept the request in a cycle where mem_req=1.
REQ-010 mem_rvalid  input  1  SHALL mark mem_rdata valid; one response per granted request, in order.
REQ-011 mem_rdata  input  32  SHALL carry the returned instruction word.
REQ-012 inst_valid  output  1  SHALL flag that inst_data/inst_pc hold the head buffer entry.
REQ-013 inst_ready  input  1  SHALL pop the head entry when inst_valid=1 and inst_ready=1.
REQ-014 inst_data  output  32  SHALL give the head instruction; inst_pc  output  32  SHALL give its address.

Function
REQ-015 FSM states IDLE, WAIT_RSP, DROP; at most one memory request outstanding.
REQ-016 mem_req SHALL equal (state==IDLE) and (count<DEPTH), decoded from registers only; mem_addr SHALL equal fetch_pc.
REQ-017 IDLE, mem_req&mem_gnt: -> WAIT_RSP, fetch_pc += 4 (mod 2^32 wrap), pending_pc <= fetch_pc.
REQ-018 WAIT_RSP, mem_rvalid: write {mem_rdata, pending_pc} to buffer tail, -> IDLE; inst_valid visible next cycle (1-cycle rvalid-to-valid latency).
REQ-019 Buffer SHALL be FIFO order; push and pop in same cycle SHALL both occur, count unchanged.
REQ-020 Redirect SHALL take priority over every same-cycle event: buffer emptied (count=0, same-cycle pop/push discarded), fetch_pc <= {redirect_pc[31:2],2'b00}.
REQ-021 Redirect next-state: from IDLE with no grant -> IDLE; from IDLE with grant -> DROP; from WAIT_RSP without rvalid -> DROP; from WAIT_RSP with rvalid -> IDLE (data dropped); from DROP without rvalid -> DROP; from DROP with rvalid -> IDLE.
REQ-022 DROP, mem_rvalid: discard data, -> IDLE; no buffer write.
REQ-023 Redirect at cycle N SHALL produce mem_req with mem_addr=redirect_pc at N+1 when state returns to IDLE.
REQ-024 Full (count==DEPTH): mem_req=0; inst_valid SHALL equal (count!=0); empty outputs hold last value, inst_valid=0.
REQ-025 mem_rvalid outside WAIT_RSP/DROP SHALL be ignored.

Reset
REQ-026 On reset: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, inst_valid=0, mem_req=0 in reset cycle, inst_data=0, inst_pc=0.
REQ-027 Reset mid-transaction SHALL abandon any outstanding response (memory reset together with block).

Configuration
REQ-028 Macro IFETCH_PERF_EN defined: outputs perf_fetch_cnt (32, +1 per buffer push) and perf_flush_cnt (32, +1 per redirect cycle) exist, reset to 0, wrap at 2^32.
REQ-029 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package ifetch_pkg SHALL hold the FSM state typedef, DEPTH default and RESET_PC default.
REQ-031 Sub-module fetch_fifo (parameterised width/depth, push/pop/flush, count) SHALL implement the buffer.

Verification
REQ-032 Reset release, gnt=1, rvalid 1 cycle after gnt, ready=1 -> inst_pc sequence 0x0,0x4,0x8 with matching data.
REQ-033 ready=0, DEPTH=4 -> exactly 4 grants, then mem_req=0 until first pop; buffer order preserved.
REQ-034 Redirect to 0x0000_0102 while WAIT_RSP -> state DROP, response discarded, next mem_addr=0x0000_0100, inst_pc=0x100.
REQ-035 Redirect, pop and rvalid in same cycle -> count=0 after edge, no stale inst_valid.
REQ-036 redirect_pc=0xFFFF_FFFC, gnt=1 -> next mem_addr=0x0000_0000 (wrap).
REQ-037 IFETCH_PERF_EN defined, 5 pushes + 2 redirects -> perf_fetch_cnt=5, perf_flush_cnt=2.
